// File: rtl/sll_seq.sv
// Multi-cycle logical shift-left unit: shifts up to STEP bits per clock.
// Ports: clk/rst_n, flush, in_valid/in_ready/a/sh, out_valid/out_ready/result, busy.
module sll_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [SHW-1:0] STEP_C = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // abort wins over everything, including an accept in IDLE
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = a;
            cnt_d   = sh;
            state_d = (sh == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // residual step uses cnt < STEP so cnt never underflows
          if (cnt_q >= STEP_C) begin
            acc_d = acc_q << STEP;
            cnt_d = cnt_q - STEP_C;
          end else begin
            acc_d = acc_q << cnt_q;
            cnt_d = '0;
          end
          if (cnt_d == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = acc_q;

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed vectors plus
// a seeded sweep against a bench-side a<<sh reference.
module tb_sll_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  sh;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_chk;
  int n_fail;

  sll_seq #(
    .WIDTH(32),
    .SHW  (5),
    .STEP (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .sh       (sh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full transaction; hold = cycles out_ready stays low in DONE
  task automatic run_op(input logic [31:0] av,
                        input logic [4:0]  shv,
                        input int          hold);
    logic [31:0] exp;
    int          lat_exp;
    int          n;
    exp     = av << shv;
    lat_exp = 1 + (int'(shv) + 3) / 4;
    a        = av;
    sh       = shv;
    in_valid = 1'b1;
    chk("in_ready_pre", {31'b0, in_ready}, 32'd1);
    tick();
    a  = $urandom;
    sh = 5'($urandom);
    n  = 1;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      chk("busy_shift", {31'b0, busy}, 32'd1);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(lat_exp));
    chk("result", result, exp);
    chk("busy_done", {31'b0, busy}, 32'd1);
    chk("in_ready_done", {31'b0, in_ready}, 32'd0);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = $urandom;
      tick();
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", result, exp);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("handoff_valid", {31'b0, out_valid}, 32'd0);
    chk("handoff_ready", {31'b0, in_ready}, 32'd1);
    chk("handoff_noacc", result, exp);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    sh        = '0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", result, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // async reset in the middle of a SHIFT
    a        = 32'h8000_0001;
    sh       = 5'd31;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(32'h0000_0001, 5'd0, 0);
    run_op(32'h8000_0001, 5'd31, 0);
    run_op(32'hDEAD_BEEF, 5'd5, 4);
    chk("deadbeef_const", result, 32'hD5B7_DDE0);
    run_op(32'h1234_5678, 5'd4, 1);
    run_op(32'hFFFF_FFFF, 5'd16, 0);

    // flush one cycle after accept
    a        = 32'hFFFF_FFFF;
    sh       = 5'd16;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_flush_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (6) begin
      tick();
      chk("flush_no_valid", {31'b0, out_valid}, 32'd0);
    end

    // flush with in_valid in IDLE must not accept
    a        = 32'h0000_00FF;
    sh       = 5'd8;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle_busy", {31'b0, busy}, 32'd0);

    run_op(32'h0000_0001, 5'd3, 0);
    chk("post_flush_res", result, 32'h0000_0008);

    // seeded sweep with random gaps and back-pressure
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      run_op($urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
